// File: rtl/grid_row_streamer.sv
// rtl/grid_row_streamer.sv - captures a ROWS*COLS Life snapshot and streams it out one row per valid/ready transfer
// Optional GRID_POP_EN adds pop_count, the live-cell count of the captured snapshot.
module grid_row_streamer #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter bit BOTTOM_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [ROWS*COLS-1:0]    grid_in,
    output logic                    busy,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [COLS-1:0]         row_data,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    row_last,
    output logic                    frame_done
`ifdef GRID_POP_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] pop_count
`endif
);

    localparam int IDX_W = $clog2(ROWS);
    localparam int POP_W = $clog2(ROWS*COLS+1);
    localparam logic [IDX_W-1:0] FIRST_IDX = BOTTOM_FIRST ? IDX_W'(ROWS-1) : '0;
    localparam logic [IDX_W-1:0] FINAL_IDX = BOTTOM_FIRST ? '0 : IDX_W'(ROWS-1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ROWS*COLS-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]       row_q, row_d;
    logic                   done_q, done_d;

    logic capture;
    logic xfer;
    logic at_final;

    // The frame_done cycle is IDLE but still refuses a new capture.
    assign capture  = (state_q == ST_IDLE) && load && !done_q;
    assign xfer     = (state_q == ST_SEND) && row_ready;
    assign at_final = (row_q == FINAL_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            row_q    <= row_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture)         state_d = ST_SEND;
            ST_SEND: if (xfer && at_final) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // The counter stops on the final row so row_data keeps its last value in IDLE.
    always_comb begin
        shadow_d = shadow_q;
        row_d    = row_q;
        done_d   = 1'b0;
        if (capture) begin
            shadow_d = grid_in;
            row_d    = FIRST_IDX;
        end
        if (xfer) begin
            if (at_final) begin
                done_d = 1'b1;
            end else if (BOTTOM_FIRST) begin
                row_d = row_q - 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy       = (state_q == ST_SEND);
        row_valid  = (state_q == ST_SEND);
        row_last   = (state_q == ST_SEND) && at_final;
        frame_done = done_q;
        row_idx    = row_q;
        row_data   = shadow_q[int'(row_q)*COLS +: COLS];
    end

`ifdef GRID_POP_EN
    logic [POP_W-1:0] pop_q, pop_d;
    logic [POP_W-1:0] row_pop;

    always_comb begin
        row_pop = '0;
        for (int i = 0; i < COLS; i++) begin
            row_pop = row_pop + POP_W'(row_data[i]);
        end
    end

    always_comb begin
        pop_d = pop_q;
        if (capture) begin
            pop_d = '0;
        end else if (xfer) begin
            pop_d = pop_q + row_pop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end

    assign pop_count = pop_q;
`endif

endmodule

// File: tb/tb_grid_row_streamer.sv
// tb/tb_grid_row_streamer.sv - randomized and directed bench for grid_row_streamer (normal and BOTTOM_FIRST instances)
module tb_grid_row_streamer;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic        row_ready;
    logic [63:0] grid_in;

    logic [1:0]       busy_v, row_valid_v, row_last_v, fd_v;
    logic [1:0][7:0]  data_v;
    logic [1:0][2:0]  idx_v;
`ifdef GRID_POP_EN
    logic [1:0][6:0]  pop_v;
`endif

    always #5 clk = ~clk;

    grid_row_streamer #(.ROWS(ROWS), .COLS(COLS), .BOTTOM_FIRST(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load(load), .grid_in(grid_in),
        .busy(busy_v[0]), .row_valid(row_valid_v[0]), .row_ready(row_ready),
        .row_data(data_v[0]), .row_idx(idx_v[0]), .row_last(row_last_v[0]),
        .frame_done(fd_v[0])
`ifdef GRID_POP_EN
        , .pop_count(pop_v[0])
`endif
    );

    grid_row_streamer #(.ROWS(ROWS), .COLS(COLS), .BOTTOM_FIRST(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load(load), .grid_in(grid_in),
        .busy(busy_v[1]), .row_valid(row_valid_v[1]), .row_ready(row_ready),
        .row_data(data_v[1]), .row_idx(idx_v[1]), .row_last(row_last_v[1]),
        .frame_done(fd_v[1])
`ifdef GRID_POP_EN
        , .pop_count(pop_v[1])
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int popc8(input logic [7:0] r);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(r[i]);
        return n;
    endfunction

    // Transfer number k of a frame addresses grid row k, or ROWS-1-k for the bottom-first instance.
    function automatic int exp_idx(input int d, input int k);
        return (d == 1) ? (ROWS - 1 - k) : k;
    endfunction

    // Frame-level model: which frame is active, how many rows have gone, and the pending done pulse.
    logic [1:0]       m_active, m_done;
    logic [1:0][63:0] m_grid;
    int               m_k[2];
    int               m_pop[2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_active[d] <= 1'b0;
                m_done[d]   <= 1'b0;
                m_k[d]      <= 0;
                m_pop[d]    <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < 2; d++) begin
                m_done[d] <= 1'b0;
                if (m_active[d]) begin
                    if (row_ready) begin
                        m_pop[d] <= m_pop[d] + popc8(m_grid[d][exp_idx(d, m_k[d])*8 +: 8]);
                        if (m_k[d] == ROWS - 1) begin
                            m_active[d] <= 1'b0;
                            m_done[d]   <= 1'b1;
                        end else begin
                            m_k[d] <= m_k[d] + 1;
                        end
                    end
                end else if (!m_done[d] && load) begin
                    m_active[d] <= 1'b1;
                    m_grid[d]   <= grid_in;
                    m_k[d]      <= 0;
                    m_pop[d]    <= 0;
                end
            end
        end
    end

    int lq_data0[$], lq_idx0[$], lq_data1[$], lq_idx1[$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, 64'(busy_v[d]), 64'(m_active[d]));
            chk("row_valid", d, 64'(row_valid_v[d]), 64'(m_active[d]));
            chk("frame_done", d, 64'(fd_v[d]), 64'(m_done[d]));
            if (m_active[d]) begin
                chk("row_idx", d, 64'(idx_v[d]), 64'(exp_idx(d, m_k[d])));
                chk("row_data", d, 64'(data_v[d]), 64'(m_grid[d][exp_idx(d, m_k[d])*8 +: 8]));
                chk("row_last", d, 64'(row_last_v[d]), 64'(m_k[d] == ROWS - 1));
            end
`ifdef GRID_POP_EN
            chk("pop_count", d, 64'(pop_v[d]), 64'(m_pop[d]));
`endif
        end
        if (row_valid_v[0] && row_ready) begin
            lq_data0.push_back(int'(data_v[0]));
            lq_idx0.push_back(int'(idx_v[0]));
        end
        if (row_valid_v[1] && row_ready) begin
            lq_data1.push_back(int'(data_v[1]));
            lq_idx1.push_back(int'(idx_v[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        lq_data0.delete(); lq_idx0.delete();
        lq_data1.delete(); lq_idx1.delete();
    endtask

    // Load g with row_ready high; returns in the frame_done cycle.
    task automatic run_frame(input logic [63:0] g);
        load = 1'b1; grid_in = g; row_ready = 1'b1;
        tick();
        load = 1'b0;
        repeat (ROWS) tick();
    endtask

    task automatic chk_log0(input string name, input logic [63:0] g);
        chk({name, "_len"}, 0, 64'(lq_data0.size()), 64'(ROWS));
        for (int k = 0; k < ROWS && k < lq_data0.size(); k++) begin
            chk({name, "_idx"}, 0, 64'(lq_idx0[k]), 64'(k));
            chk({name, "_data"}, 0, 64'(lq_data0[k]), 64'(g[k*8 +: 8]));
        end
    endtask

    logic [7:0] exp1 [8];
    int cap_cyc;

    initial begin
        exp1 = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        reset_n = 1'b0; load = 1'b0; row_ready = 1'b0; grid_in = '0;
        repeat (2) tick();
        chk("rst_busy", 0, 64'(busy_v[0]), 64'd0);
        chk("rst_valid", 0, 64'(row_valid_v[0]), 64'd0);
        chk("rst_data", 0, 64'(data_v[0]), 64'd0);
        chk("rst_idx", 1, 64'(idx_v[1]), 64'd0);
        chk("rst_last", 1, 64'(row_last_v[1]), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Back-to-back frame
        clear_logs();
        run_frame(64'h0123456789ABCDEF);
        chk("t1_fd", 0, 64'(fd_v[0]), 64'd1);
        chk("t1_busy", 0, 64'(busy_v[0]), 64'd0);
`ifdef GRID_POP_EN
        chk("t1_pop", 0, 64'(pop_v[0]), 64'd32);
`endif
        chk("t1_len", 0, 64'(lq_data0.size()), 64'd8);
        for (int k = 0; k < 8 && k < lq_data0.size(); k++) begin
            chk("t1_data", 0, 64'(lq_data0[k]), 64'(exp1[k]));
            chk("t1_idx", 0, 64'(lq_idx0[k]), 64'(k));
        end
        tick();
        chk("t1_fd_pulse", 0, 64'(fd_v[0]), 64'd0);
        tick();

        // Stall three cycles on idx 2
        clear_logs();
        load = 1'b1; grid_in = 64'h0123456789ABCDEF; row_ready = 1'b1;
        tick();
        load = 1'b0;
        repeat (2) tick();
        row_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("t2_hold_data", 0, 64'(data_v[0]), 64'hAB);
            chk("t2_hold_idx", 0, 64'(idx_v[0]), 64'd2);
            tick();
        end
        row_ready = 1'b1;
        repeat (6) tick();
        chk("t2_fd", 0, 64'(fd_v[0]), 64'd1);
        chk_log0("t2", 64'h0123456789ABCDEF);
        repeat (2) tick();

        // Load and grid_in changes mid-frame are ignored
        clear_logs();
        load = 1'b1; grid_in = 64'h0123456789ABCDEF; row_ready = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("t3_idx4", 0, 64'(idx_v[0]), 64'd4);
        load = 1'b1; grid_in = 64'hDEADBEEFCAFEF00D;
        tick();
        load = 1'b0; grid_in = 64'h5555AAAA5555AAAA;
        chk("t3_busy", 0, 64'(busy_v[0]), 64'd1);
        repeat (3) tick();
        chk("t3_fd", 0, 64'(fd_v[0]), 64'd1);
        chk_log0("t3", 64'h0123456789ABCDEF);
        repeat (2) tick();

        // Asynchronous reset mid-frame
        load = 1'b1; grid_in = 64'h0123456789ABCDEF; row_ready = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        chk("t4_idx5", 0, 64'(idx_v[0]), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("t4_busy", 0, 64'(busy_v[0]), 64'd0);
        chk("t4_valid", 0, 64'(row_valid_v[0]), 64'd0);
        chk("t4_data", 0, 64'(data_v[0]), 64'd0);
        chk("t4_idx", 0, 64'(idx_v[0]), 64'd0);
        chk("t4_last", 0, 64'(row_last_v[0]), 64'd0);
        tick();
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("t4_no_fd", 0, 64'(fd_v[0]), 64'd0);
        end
        clear_logs();
        run_frame(64'h0123456789ABCDEF);
        chk_log0("t4", 64'h0123456789ABCDEF);
        repeat (2) tick();

        // Bottom-first order, then load in the frame_done cycle
        clear_logs();
        load = 1'b1; grid_in = 64'hFF00000000000001; row_ready = 1'b1;
        tick();
        cap_cyc = cyc;
        load = 1'b0;
        repeat (ROWS) tick();
        chk("t5_len", 1, 64'(lq_data1.size()), 64'd8);
        if (lq_data1.size() == 8) begin
            chk("t5_first_data", 1, 64'(lq_data1[0]), 64'hFF);
            chk("t5_first_idx", 1, 64'(lq_idx1[0]), 64'd7);
            chk("t5_last_data", 1, 64'(lq_data1[7]), 64'h01);
            chk("t5_last_idx", 1, 64'(lq_idx1[7]), 64'd0);
        end
        chk("t6_fd", 0, 64'(fd_v[0]), 64'd1);
        load = 1'b1; grid_in = 64'h0F0F0F0F0F0F0F0F;
        tick();
        chk("t6_ignored", 0, 64'(busy_v[0]), 64'd0);
        tick();
        load = 1'b0;
        chk("t6_accepted", 0, 64'(row_valid_v[0]), 64'd1);
        chk("t6_period", 0, 64'(cyc - cap_cyc), 64'(ROWS + 2));
        repeat (ROWS) tick();
`ifdef GRID_POP_EN
        chk("t6_pop", 0, 64'(pop_v[0]), 64'd32);
`endif
        repeat (2) tick();

        // Full grid
        run_frame(64'hFFFFFFFFFFFFFFFF);
`ifdef GRID_POP_EN
        chk("full_pop", 0, 64'(pop_v[0]), 64'd64);
`endif
        chk("full_fd", 1, 64'(fd_v[1]), 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            load      = ($urandom_range(0, 3) == 0);
            row_ready = ($urandom_range(0, 3) != 0);
            grid_in   = {$urandom, $urandom};
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        load = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
